mult_shift_add_datapath: RTL and testbench

Shift-and-add datapath for the sequential unsigned multiplier, directly downstream of the multiplier Moore control FSM. It consumes the FSM's `load`, `shift`, `sync_reset` and `enable` strobes. It returns the `finish_load`, `finish_shift`, `finish` and `reset_done` status flags that drive the FSM's state transitions. It holds the registered 2·WIDTH-bit product until the next result overwrites it.

---
 rtl/mult_shift_add_datapath_if.sv | 33 +++
 rtl/mult_shift_add_datapath.sv | 91 +++++++++
 tb/tb_mult_shift_add_datapath.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mult_shift_add_datapath_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_shift_add_datapath_if
// Purpose  : Control strobes, operands and status flags shared by the
//            multiplier control FSM and its shift-and-add datapath.
// Revision : 1.0
// ============================================================================
interface mult_shift_add_datapath_if #(
   parameter int WIDTH = 8
);
   logic                 load;
   logic                 shift;
   logic                 sync_reset;
   logic                 enable;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic [2*WIDTH-1:0]   product;
   logic                 finish_load;
   logic                 finish_shift;
   logic                 finish;
   logic                 reset_done;

   modport master (
      output load, shift, sync_reset, enable, multiplicand, multiplier,
      input  product, finish_load, finish_shift, finish, reset_done
   );

   modport slave (
      input  load, shift, sync_reset, enable, multiplicand, multiplier,
      output product, finish_load, finish_shift, finish, reset_done
   );
endinterface
`default_nettype wire

// File: rtl/mult_shift_add_datapath.sv
`default_nettype none
// ============================================================================
// Module   : mult_shift_add_datapath
// Purpose  : Shift-and-add datapath of the sequential unsigned multiplier,
//            driven by the Moore control FSM strobes. Optional early exit
//            when no multiplier bits remain: define MULT_EARLY_EXIT_EN.
// Revision : 1.0
// ============================================================================
module mult_shift_add_datapath #(
   parameter int WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   mult_shift_add_datapath_if.slave  bus
);
   localparam int                  c_cnt_w   = $clog2(WIDTH + 1);
   localparam logic [c_cnt_w-1:0]  c_cnt_max = c_cnt_w'(WIDTH);
   localparam logic [c_cnt_w-1:0]  c_cnt_one = c_cnt_w'(1);

   logic [2*WIDTH-1:0]  r_mcand;
   logic [WIDTH-1:0]    r_mplier;
   logic [2*WIDTH-1:0]  r_acc;
   logic [c_cnt_w-1:0]  r_cnt;
   logic [2*WIDTH-1:0]  r_product;
   logic                r_finish_load;
   logic                r_finish;
   logic                r_reset_done;

   logic                w_done;
   logic [2*WIDTH-1:0]  w_acc_next;

`ifdef MULT_EARLY_EXIT_EN
   assign w_done = (r_cnt == c_cnt_max) || ((r_mplier == '0) && (r_cnt != '0));
`else
   assign w_done = (r_cnt == c_cnt_max);
`endif

   // Full 2*WIDTH-bit sum; A*B never exceeds (2^WIDTH-1)^2 so no carry-out.
   assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mcand       <= '0;
         r_mplier      <= '0;
         r_acc         <= '0;
         r_cnt         <= '0;
         r_product     <= '0;
         r_finish_load <= 1'b0;
         r_finish      <= 1'b0;
         r_reset_done  <= 1'b0;
      end else if (!bus.sync_reset) begin
         r_mcand       <= '0;
         r_mplier      <= '0;
         r_acc         <= '0;
         r_cnt         <= '0;
         r_finish_load <= 1'b0;
         r_finish      <= 1'b0;
         r_reset_done  <= 1'b1;
      end else if (bus.enable) begin
         if (bus.load) begin
            r_mcand       <= {{WIDTH{1'b0}}, bus.multiplicand};
            r_mplier      <= bus.multiplier;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_finish_load <= 1'b1;
            r_reset_done  <= 1'b0;
         end else begin
            r_finish_load <= 1'b0;
            if (bus.shift) begin
               // Strobes arriving after completion are the FSM's transition cycle.
               if (!w_done) begin
                  r_acc    <= w_acc_next;
                  r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
                  r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                  r_cnt    <= r_cnt + c_cnt_one;
               end
            end else if (w_done && !r_finish) begin
               r_product <= r_acc;
               r_finish  <= 1'b1;
            end
         end
      end
   end

   assign bus.product      = r_product;
   assign bus.finish_load  = r_finish_load;
   assign bus.finish_shift = w_done;
   assign bus.finish       = r_finish;
   assign bus.reset_done   = r_reset_done;
endmodule
`default_nettype wire

// File: tb/tb_mult_shift_add_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_shift_add_datapath
// Purpose  : Self-checking bench: table vectors, random operands and
//            hand-written reset / enable / extra-shift sequences.
// Revision : 1.0
// ============================================================================
module tb_mult_shift_add_datapath;
   localparam int WIDTH = 8;

   typedef struct {
      logic [WIDTH-1:0]    a;
      logic [WIDTH-1:0]    b;
      logic [2*WIDTH-1:0]  exp_product;
      int                  extra_shifts;
      int                  drop_at;
   } vec_t;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;
   logic [2*WIDTH-1:0] prev_product;
   vec_t vecs [6];

   mult_shift_add_datapath_if #(.WIDTH(WIDTH)) bus ();

   mult_shift_add_datapath #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Number of shift iterations before finish_shift, from the operand alone.
   function automatic int exp_shifts(input logic [WIDTH-1:0] b);
`ifdef MULT_EARLY_EXIT_EN
      for (int k = 1; k <= WIDTH; k++)
         if ((b >> k) == 0) return k;
      return WIDTH;
`else
      return WIDTH;
`endif
   endfunction

   task automatic do_mult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int extra, input int drop_at);
      int n;
      logic [2*WIDTH-1:0] expected;
      expected = (2*WIDTH)'(a) * (2*WIDTH)'(b);
      bus.sync_reset = 1'b0; bus.load = 1'b0; bus.shift = 1'b0; bus.enable = 1'b1;
      tick();
      check("reset_done_after_sync", 32'(bus.reset_done), 32'd1);
      check("finish_after_sync", 32'(bus.finish), 32'd0);
      check("product_kept_after_sync", 32'(bus.product), 32'(prev_product));
      bus.sync_reset = 1'b1; bus.load = 1'b1;
      bus.multiplicand = a; bus.multiplier = b;
      tick();
      check("finish_load", 32'(bus.finish_load), 32'd1);
      check("reset_done_cleared", 32'(bus.reset_done), 32'd0);
      tick();
      bus.load = 1'b0; bus.shift = 1'b1;
      n = 0;
      while (n < 4 * WIDTH) begin
         if (drop_at != 0 && n == drop_at) begin
            bus.enable = 1'b0;
            repeat (4) tick();
            check("shift_held_disabled", 32'(bus.finish_shift), 32'd0);
            bus.enable = 1'b1;
         end
         tick();
         n++;
         if (n == 1) check("finish_load_drop", 32'(bus.finish_load), 32'd0);
         if (bus.finish_shift) break;
      end
      check("shift_count", 32'(n), 32'(exp_shifts(b)));
      repeat (1 + extra) tick();
      check("finish_shift_held", 32'(bus.finish_shift), 32'd1);
      check("product_before_finish", 32'(bus.product), 32'(prev_product));
      bus.shift = 1'b0;
      tick();
      check("product", 32'(bus.product), 32'(expected));
      check("finish", 32'(bus.finish), 32'd1);
      prev_product = expected;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      prev_product = '0;
      vecs[0] = '{a: 8'd13,  b: 8'd11,  exp_product: 16'h008F, extra_shifts: 0, drop_at: 0};
      vecs[1] = '{a: 8'd255, b: 8'd255, exp_product: 16'hFE01, extra_shifts: 0, drop_at: 0};
      vecs[2] = '{a: 8'd0,   b: 8'd200, exp_product: 16'h0000, extra_shifts: 0, drop_at: 0};
      vecs[3] = '{a: 8'd3,   b: 8'd2,   exp_product: 16'h0006, extra_shifts: 0, drop_at: 0};
      vecs[4] = '{a: 8'd13,  b: 8'd11,  exp_product: 16'h008F, extra_shifts: 3, drop_at: 0};
      vecs[5] = '{a: 8'hC5,  b: 8'h9B,  exp_product: 16'h7747, extra_shifts: 0, drop_at: 4};

      reset = 1'b1;
      bus.load = 1'b0; bus.shift = 1'b0; bus.sync_reset = 1'b1; bus.enable = 1'b1;
      bus.multiplicand = '0; bus.multiplier = '0;
      repeat (2) tick();
      check("rst_product", 32'(bus.product), 32'd0);
      check("rst_finish_load", 32'(bus.finish_load), 32'd0);
      check("rst_finish_shift", 32'(bus.finish_shift), 32'd0);
      check("rst_finish", 32'(bus.finish), 32'd0);
      check("rst_reset_done", 32'(bus.reset_done), 32'd0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) begin
         do_mult(vecs[i].a, vecs[i].b, vecs[i].extra_shifts, vecs[i].drop_at);
         check("table_product", 32'(bus.product), 32'(vecs[i].exp_product));
      end

      for (int i = 0; i < 20; i++)
         do_mult(WIDTH'($urandom), WIDTH'($urandom), int'($urandom_range(0, 2)), 0);

      // Asynchronous reset part-way through the shift phase.
      bus.sync_reset = 1'b0; tick();
      bus.sync_reset = 1'b1; bus.load = 1'b1;
      bus.multiplicand = 8'd200; bus.multiplier = 8'd255;
      repeat (2) tick();
      bus.load = 1'b0; bus.shift = 1'b1;
      repeat (4) tick();
      #2;
      reset = 1'b1;
      #1;
      check("async_product", 32'(bus.product), 32'd0);
      check("async_finish_load", 32'(bus.finish_load), 32'd0);
      check("async_finish_shift", 32'(bus.finish_shift), 32'd0);
      check("async_finish", 32'(bus.finish), 32'd0);
      check("async_reset_done", 32'(bus.reset_done), 32'd0);
      bus.shift = 1'b0;
      #1;
      reset = 1'b0;
      prev_product = '0;
      tick();
      do_mult(8'd7, 8'd9, 0, 0);
      check("post_reset_product", 32'(bus.product), 32'h003F);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
